// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, depth and entry type for the write-back queue
package wb_pkg;
  localparam int REG_AW   = 6;
  localparam int REG_DW   = 32;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] val;
  } wb_entry_t;

  // Occupancy counter must represent DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - producer, register-file write and read-correction signals
interface wb_queue_if
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) ();
  localparam int CW = cnt_w(DEPTH);

  logic          InValid;
  logic          InReady;
  logic [AW-1:0] InAddr;
  logic [DW-1:0] InVal;
  logic          Write;
  logic [AW-1:0] Waddr;
  logic [DW-1:0] WVal;
  logic [AW-1:0] Raddr;
  logic [DW-1:0] RegRval;
  logic [DW-1:0] Rval;
  logic          Pending;
  logic [CW-1:0] Count;

  modport master (
    output InValid, InAddr, InVal, Raddr, RegRval,
    input  InReady, Write, Waddr, WVal, Rval, Pending, Count
  );

  modport slave (
    input  InValid, InAddr, InVal, Raddr, RegRval,
    output InReady, Write, Waddr, WVal, Rval, Pending, Count
  );
endinterface

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest valid entry whose address matches the read address
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic [AW-1:0]              i_addr [DEPTH],
  input  logic [DW-1:0]              i_val  [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  input  logic [AW-1:0]              i_raddr,
  output logic                       o_hit,
  output logic [DW-1:0]              o_val
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so the last hit seen is the youngest.
  always_comb begin
    o_hit = 1'b0;
    o_val = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (i_valid[w_idx] && (i_addr[w_idx] == i_raddr)) begin
        o_hit = 1'b1;
        o_val = i_val[w_idx];
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back FIFO feeding the register file
// Define WB_BYPASS_EN to forward buffered results onto Rval.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic        Clk,
  input  logic        Rst_n,
  wb_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_val  [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_match;

  assign bus.InReady = (r_count != FULL_CNT);
  assign bus.Write   = (r_count != '0);
  assign bus.Waddr   = r_addr[r_head];
  assign bus.WVal    = r_val[r_head];
  assign bus.Count   = r_count;

  assign w_push = bus.InValid & bus.InReady;
  assign w_pop  = bus.Write;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_val[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= bus.InAddr;
        r_val[r_tail]  <= bus.InVal;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] w_age;
    assign w_age      = PW'(g) - r_head;
    assign w_valid[g] = ({1'b0, w_age} < r_count);
    assign w_match[g] = (r_addr[g] == bus.Raddr);
  end

  assign bus.Pending = |(w_valid & w_match);

`ifdef WB_BYPASS_EN
  logic          w_hit;
  logic [DW-1:0] w_fwd_val;

  wb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .i_addr  (r_addr),
    .i_val   (r_val),
    .i_valid (w_valid),
    .i_head  (r_head),
    .i_raddr (bus.Raddr),
    .o_hit   (w_hit),
    .o_val   (w_fwd_val)
  );

  assign bus.Rval = w_hit ? w_fwd_val : bus.RegRval;
`else
  assign bus.Rval = bus.RegRval;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - randomized self-checking bench with a queue-based reference model
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = WB_DEPTH;
  localparam int AW    = REG_AW;
  localparam int DW    = REG_DW;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  always #5 Clk = ~Clk;

  wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  wb_entry_t model_q[$];
  wb_entry_t dut_log[$];
  wb_entry_t sent[$];

  function automatic logic exp_pending();
    foreach (model_q[i]) if (model_q[i].addr == bus.Raddr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_rval();
    logic [DW-1:0] r;
    r = bus.RegRval;
`ifdef WB_BYPASS_EN
    foreach (model_q[i]) if (model_q[i].addr == bus.Raddr) r = model_q[i].val;
`endif
    return r;
  endfunction

  // Advance one clock: log what the DUT writes, then apply the queue rules.
  task automatic cycle();
    wb_entry_t e;
    bit do_push;
    if (bus.Write) dut_log.push_back('{addr: bus.Waddr, val: bus.WVal});
    do_push = bus.InValid && (model_q.size() < DEPTH);
    if (model_q.size() != 0) e = model_q.pop_front();
    if (do_push) model_q.push_back('{addr: bus.InAddr, val: bus.InVal});
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_checks++; if (bus.Write !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %b expected 0", bus.Write); end
    n_checks++; if (bus.InReady !== 1'b1) begin n_errors++; $display("FAIL reset_inready: got %b expected 1", bus.InReady); end
    n_checks++; if (bus.Count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.Count); end
    Rst_n = 1'b1;
    cycle();
    n_checks++; if (bus.Write !== 1'b0) begin n_errors++; $display("FAIL post_reset_write: got %b expected 0", bus.Write); end
  endtask

  task automatic test_single();
    bus.InValid = 1'b1; bus.InAddr = 6'd5; bus.InVal = 32'hDEADBEEF;
    cycle();
    bus.InValid = 1'b0;
    #1;
    n_checks++; if (bus.Write !== 1'b1) begin n_errors++; $display("FAIL single_write: got %b expected 1", bus.Write); end
    n_checks++; if (bus.Waddr !== 6'd5) begin n_errors++; $display("FAIL single_waddr: got %0d expected 5", bus.Waddr); end
    n_checks++; if (bus.WVal !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wval: got %0h expected deadbeef", bus.WVal); end
    cycle();
    n_checks++; if (bus.Write !== 1'b0) begin n_errors++; $display("FAIL single_drain_write: got %b expected 0", bus.Write); end
    n_checks++; if (bus.Count !== '0) begin n_errors++; $display("FAIL single_drain_count: got %0d expected 0", bus.Count); end
    // Address 0 behaves like any other register.
    bus.InValid = 1'b1; bus.InAddr = 6'd0; bus.InVal = 32'h1234_5678; bus.Raddr = 6'd0;
    cycle();
    bus.InValid = 1'b0;
    #1;
    n_checks++; if (bus.Pending !== 1'b1) begin n_errors++; $display("FAIL addr0_pending: got %b expected 1", bus.Pending); end
    n_checks++; if (bus.Waddr !== 6'd0 || bus.WVal !== 32'h1234_5678) begin n_errors++; $display("FAIL addr0_write: got %0d/%0h expected 0/12345678", bus.Waddr, bus.WVal); end
    cycle();
  endtask

  task automatic test_stream();
    dut_log.delete();
    sent.delete();
    for (int i = 0; i < 8; i++) begin
      bus.InValid = 1'b1;
      bus.InAddr  = AW'(i + 10);
      bus.InVal   = $urandom;
      sent.push_back('{addr: bus.InAddr, val: bus.InVal});
      #1;
      n_checks++; if (int'(bus.Count) > DEPTH) begin n_errors++; $display("FAIL stream_count_max: got %0d expected <= %0d", bus.Count, DEPTH); end
      n_checks++; if (bus.InReady !== (model_q.size() < DEPTH)) begin n_errors++; $display("FAIL stream_inready: got %b expected %b", bus.InReady, model_q.size() < DEPTH); end
      cycle();
    end
    bus.InValid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    n_checks++; if (dut_log.size() != sent.size()) begin n_errors++; $display("FAIL stream_write_count: got %0d expected %0d", dut_log.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < dut_log.size(); i++) begin
      n_checks++;
      if (dut_log[i] !== sent[i]) begin
        n_errors++;
        $display("FAIL stream_order[%0d]: got %0d/%0h expected %0d/%0h", i, dut_log[i].addr, dut_log[i].val, sent[i].addr, sent[i].val);
      end
    end
  endtask

  task automatic test_same_addr();
    dut_log.delete();
    bus.Raddr = 6'd9; bus.RegRval = 32'd0;
    bus.InValid = 1'b1; bus.InAddr = 6'd9; bus.InVal = 32'd1;
    cycle();
    bus.InVal = 32'd2;
    #1;
    n_checks++; if (bus.Rval !== exp_rval()) begin n_errors++; $display("FAIL same_addr_rval_first: got %0h expected %0h", bus.Rval, exp_rval()); end
    cycle();
    bus.InValid = 1'b0;
    #1;
    n_checks++; if (bus.Pending !== 1'b1) begin n_errors++; $display("FAIL same_addr_pending: got %b expected 1", bus.Pending); end
`ifdef WB_BYPASS_EN
    n_checks++; if (bus.Rval !== 32'd2) begin n_errors++; $display("FAIL same_addr_rval: got %0h expected 2", bus.Rval); end
`else
    n_checks++; if (bus.Rval !== 32'd0) begin n_errors++; $display("FAIL same_addr_rval: got %0h expected 0", bus.Rval); end
`endif
    cycle();
    n_checks++; if (bus.Pending !== 1'b0) begin n_errors++; $display("FAIL same_addr_pending_clear: got %b expected 0", bus.Pending); end
    n_checks++; if (dut_log.size() != 2 || dut_log[0].val !== 32'd1 || dut_log[1].val !== 32'd2) begin
      n_errors++; $display("FAIL same_addr_no_coalesce: got %0d writes expected 2 in order 1,2", dut_log.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      bus.InValid = 1'b1;
      bus.InAddr  = AW'($urandom_range(0, 63));
      bus.InVal   = $urandom;
      #1;
      n_checks++; if (int'(bus.Count) !== model_q.size()) begin n_errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, bus.Count, model_q.size()); end
      if (model_q.size() != 0) begin
        n_checks++;
        if (bus.Waddr !== model_q[0].addr || bus.WVal !== model_q[0].val) begin
          n_errors++; $display("FAIL wrap_head[%0d]: got %0d/%0h expected %0d/%0h", i, bus.Waddr, bus.WVal, model_q[0].addr, model_q[0].val);
        end
      end
      cycle();
    end
    bus.InValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.InValid = 1'b1; bus.InAddr = 6'd3; bus.InVal = 32'hCAFE;
    cycle();
    cycle();
    n_checks++; if (int'(bus.Count) !== model_q.size()) begin n_errors++; $display("FAIL reset_mid_precount: got %0d expected %0d", bus.Count, model_q.size()); end
    Rst_n = 1'b0;
    #1;
    n_checks++; if (bus.Write !== 1'b0) begin n_errors++; $display("FAIL reset_mid_write: got %b expected 0", bus.Write); end
    n_checks++; if (bus.Count !== '0) begin n_errors++; $display("FAIL reset_mid_count: got %0d expected 0", bus.Count); end
    model_q.delete();
    bus.InValid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    dut_log.delete();
    for (int i = 0; i < 4; i++) cycle();
    n_checks++; if (dut_log.size() != 0) begin n_errors++; $display("FAIL reset_mid_no_writes: got %0d expected 0", dut_log.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.InValid = ($urandom_range(0, 3) != 0);
      bus.InAddr  = AW'($urandom_range(0, 7));
      bus.InVal   = $urandom;
      bus.Raddr   = AW'($urandom_range(0, 7));
      bus.RegRval = $urandom;
      #1;
      n_checks++; if (int'(bus.Count) !== model_q.size()) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, bus.Count, model_q.size()); end
      n_checks++; if (bus.Write !== (model_q.size() != 0)) begin n_errors++; $display("FAIL rand_write[%0d]: got %b expected %b", i, bus.Write, model_q.size() != 0); end
      n_checks++; if (bus.InReady !== (model_q.size() < DEPTH)) begin n_errors++; $display("FAIL rand_inready[%0d]: got %b expected %b", i, bus.InReady, model_q.size() < DEPTH); end
      n_checks++; if (bus.Pending !== exp_pending()) begin n_errors++; $display("FAIL rand_pending[%0d]: got %b expected %b", i, bus.Pending, exp_pending()); end
      n_checks++; if (bus.Rval !== exp_rval()) begin n_errors++; $display("FAIL rand_rval[%0d]: got %0h expected %0h", i, bus.Rval, exp_rval()); end
      if (model_q.size() != 0) begin
        n_checks++;
        if (bus.Waddr !== model_q[0].addr || bus.WVal !== model_q[0].val) begin
          n_errors++; $display("FAIL rand_head[%0d]: got %0d/%0h expected %0d/%0h", i, bus.Waddr, bus.WVal, model_q[0].addr, model_q[0].val);
        end
      end
      cycle();
    end
    bus.InValid = 1'b0;
  endtask

  initial begin
    bus.InValid = 1'b0;
    bus.InAddr  = '0;
    bus.InVal   = '0;
    bus.Raddr   = '0;
    bus.RegRval = '0;
    test_reset();
    test_single();
    test_stream();
    test_same_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
